// File: rtl/wfi_ctrl.sv
// WFI execution controller: stalls M until an enabled interrupt, a flush or a TW timeout.
// Optional build macro WFI_CYCLE_COUNT_EN adds the WFICyclesM wait-cycle counter output.
module wfi_ctrl #(
    parameter int         TIMEOUT_BIT = 16,
    parameter bit         U_SUPPORTED = 1'b1,
    parameter bit         S_SUPPORTED = 1'b1,
    parameter logic [1:0] M_MODE      = 2'b11,
    parameter logic [1:0] S_MODE      = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wfiM,
    input  logic        FlushM,
    input  logic        PendingIntM,
    input  logic [1:0]  PrivilegeModeW,
    input  logic        STATUS_TW,
    output logic        WFIStallM,
    output logic        WFIWakeM,
`ifdef WFI_CYCLE_COUNT_EN
    output logic        WFITimeoutM,
    output logic [31:0] WFICyclesM
`else
    output logic        WFITimeoutM
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        WAKE = 2'b10,
        TMO  = 2'b11
    } stateT;

    stateT state, nextState;
    logic  timeoutHit;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    generate
        if (U_SUPPORTED) begin : genTimeout
            localparam logic [TIMEOUT_BIT:0] CountOne = {{TIMEOUT_BIT{1'b0}}, 1'b1};
            logic [TIMEOUT_BIT:0] count;
            logic                 notMachine;
            logic                 elig;

            // Eligibility is re-evaluated every cycle so a mode or TW change mid-wait takes effect at once.
            assign notMachine = (PrivilegeModeW != M_MODE);
            assign elig = (STATUS_TW & notMachine) |
                          (S_SUPPORTED & notMachine & (PrivilegeModeW != S_MODE));
            assign timeoutHit = elig & count[TIMEOUT_BIT];

            always_ff @(posedge clk or posedge reset) begin
                if (reset)               count <= '0;
                else if (state == IDLE)  count <= '0;
                else if (state == WAIT)  count <= count + CountOne;
            end
        end else begin : genNoTimeout
            assign timeoutHit = 1'b0;
        end
    endgenerate

    always_comb begin
        nextState   = state;
        WFIStallM   = 1'b0;
        WFIWakeM    = 1'b0;
        WFITimeoutM = 1'b0;
        case (state)
            IDLE: begin
                // Stall in the same cycle the WFI arrives so nothing behind it advances.
                if (wfiM & ~FlushM) begin
                    WFIStallM = 1'b1;
                    nextState = PendingIntM ? WAKE : WAIT;
                end
            end
            WAIT: begin
                WFIStallM = 1'b1;
                if (FlushM)           nextState = IDLE;
                else if (PendingIntM) nextState = WAKE;
                else if (timeoutHit)  nextState = TMO;
            end
            WAKE: begin
                WFIWakeM  = 1'b1;
                nextState = IDLE;
            end
            TMO: begin
                WFITimeoutM = 1'b1;
                nextState   = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

`ifdef WFI_CYCLE_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)              WFICyclesM <= 32'd0;
        else if (state == WAIT) WFICyclesM <= WFICyclesM + 32'd1;
    end
`endif

endmodule

// File: tb/tb_wfi_ctrl.sv
// Scoreboard bench for wfi_ctrl: stimulus queues expected pulses, a negedge monitor retires them.
module tb_wfi_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        wfiM;
    logic        FlushM;
    logic        PendingIntM;
    logic [1:0]  PrivilegeModeW;
    logic        STATUS_TW;
    logic        WFIStallM;
    logic        WFIWakeM;
    logic        WFITimeoutM;
`ifdef WFI_CYCLE_COUNT_EN
    logic [31:0] WFICyclesM;
`endif

    localparam int KindWake = 1;
    localparam int KindTmo  = 2;

    typedef struct {
        int    kind;
        int    stall;
        string name;
    } evT;

    evT expQ[$];
    int checks = 0;
    int passes = 0;
    int stallRun = 0;

    always #5 clk = ~clk;

    wfi_ctrl #(.TIMEOUT_BIT(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .wfiM           (wfiM),
        .FlushM         (FlushM),
        .PendingIntM    (PendingIntM),
        .PrivilegeModeW (PrivilegeModeW),
        .STATUS_TW      (STATUS_TW),
        .WFIStallM      (WFIStallM),
        .WFIWakeM       (WFIWakeM),
`ifdef WFI_CYCLE_COUNT_EN
        .WFITimeoutM    (WFITimeoutM),
        .WFICyclesM     (WFICyclesM)
`else
        .WFITimeoutM    (WFITimeoutM)
`endif
    );

    function automatic void check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endfunction

    // Monitor: a pulse retires one expected event, checking its kind and the stall cycles before it.
    always @(negedge clk) begin
        if (reset) begin
            stallRun <= 0;
        end else if (WFIWakeM | WFITimeoutM) begin
            int kind;
            evT e;
            kind = (WFITimeoutM ? KindTmo : 0) + (WFIWakeM ? KindWake : 0);
            if (expQ.size() == 0) begin
                check("unexpected pulse", kind, 0);
            end else begin
                e = expQ.pop_front();
                check({e.name, " kind"}, kind, e.kind);
                check({e.name, " stall"}, stallRun, e.stall);
            end
            stallRun <= 0;
        end else if (WFIStallM) begin
            stallRun <= stallRun + 1;
        end else begin
            stallRun <= 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expectEv(input int kind, input int stall, input string name);
        evT e;
        e.kind  = kind;
        e.stall = stall;
        e.name  = name;
        expQ.push_back(e);
    endtask

    // WFI with the interrupt raised n cycles later: n WAIT cycles, n+1 stall cycles, then a wake.
    task automatic waitThenInt(input int n, input string name);
        expectEv(KindWake, n + 1, name);
        wfiM = 1'b1;
        tick(n);
        PendingIntM = 1'b1;
        tick(1);
        wfiM = 1'b0;
        PendingIntM = 1'b0;
        tick(2);
    endtask

    // TIMEOUT_BIT=4: 17 WAIT cycles (count 0..16) plus the entry cycle give 18 stall cycles.
    task automatic timeoutRun(input string name, input logic flushInTmo);
        expectEv(KindTmo, 18, name);
        wfiM = 1'b1;
        tick(18);
        wfiM = 1'b0;
        FlushM = flushInTmo;
        tick(1);
        FlushM = 1'b0;
        tick(2);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wfiM = 1'b0;
        FlushM = 1'b0;
        PendingIntM = 1'b0;
        PrivilegeModeW = 2'b11;
        STATUS_TW = 1'b0;
        #1;
        check("reset stall", int'(WFIStallM), 0);
        check("reset wake", int'(WFIWakeM), 0);
        check("reset timeout", int'(WFITimeoutM), 0);
`ifdef WFI_CYCLE_COUNT_EN
        check("reset cycles", int'(WFICyclesM), 0);
`endif
        tick(2);
        reset = 1'b0;
        tick(1);

`ifdef WFI_CYCLE_COUNT_EN
        waitThenInt(5, "count wait5");
        waitThenInt(7, "count wait7");
        check("wait cycle total", int'(WFICyclesM), 12);
`endif

        waitThenInt(0, "immediate int");
        waitThenInt(10, "int after 10");

        PrivilegeModeW = 2'b00;
        STATUS_TW = 1'b0;
        timeoutRun("U-mode timeout", 1'b0);
        waitThenInt(17, "int beats timeout");

        expectEv(KindWake, 31, "elig drop");
        wfiM = 1'b1;
        tick(10);
        PrivilegeModeW = 2'b11;
        tick(20);
        PendingIntM = 1'b1;
        tick(1);
        wfiM = 1'b0;
        PendingIntM = 1'b0;
        tick(2);

        PrivilegeModeW = 2'b01;
        STATUS_TW = 1'b1;
        timeoutRun("S-mode TW timeout flushed", 1'b1);
        STATUS_TW = 1'b0;
        waitThenInt(30, "S-mode no TW");

        PrivilegeModeW = 2'b11;
        STATUS_TW = 1'b1;
        waitThenInt(100, "M-mode TW");

        wfiM = 1'b1;
        FlushM = 1'b1;
        #1;
        check("flushed wfi stall", int'(WFIStallM), 0);
        tick(1);
        wfiM = 1'b0;
        FlushM = 1'b0;
        #1;
        check("flushed wfi stays idle", int'(WFIStallM), 0);
        tick(1);

        wfiM = 1'b1;
        tick(3);
        FlushM = 1'b1;
        PendingIntM = 1'b1;
        tick(1);
        wfiM = 1'b0;
        FlushM = 1'b0;
        PendingIntM = 1'b0;
        check("flush exit stall", int'(WFIStallM), 0);
        check("flush exit wake", int'(WFIWakeM), 0);
        check("flush exit timeout", int'(WFITimeoutM), 0);
        tick(3);

        PrivilegeModeW = 2'b00;
        STATUS_TW = 1'b0;
        wfiM = 1'b1;
        tick(5);
        check("mid-wait stall", int'(WFIStallM), 1);
        wfiM = 1'b0;
        reset = 1'b1;
        #1;
        check("async reset stall", int'(WFIStallM), 0);
        check("async reset wake", int'(WFIWakeM), 0);
        check("async reset timeout", int'(WFITimeoutM), 0);
`ifdef WFI_CYCLE_COUNT_EN
        check("async reset cycles", int'(WFICyclesM), 0);
`endif
        tick(2);
        reset = 1'b0;
        tick(20);
        check("no pulse after reset", int'(WFIWakeM | WFITimeoutM), 0);

        tick(3);
        check("expected events drained", expQ.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
